// File: rtl/sim_result_monitor.sv
// End-of-test monitor for cpu6 system benches: holds the core in reset, then watches
// data-memory writes for the pass signature, illegal writes or a run-time timeout.
module sim_result_monitor #(
    parameter int XLEN          = 32,
    parameter int PASS_ADDR     = 84,
    parameter int PASS_DATA     = 7,
    parameter int SCRATCH_BASE  = 80,
    parameter int SCRATCH_BYTES = 4,
    parameter int RST_HOLD      = 2,
    parameter int TIMEOUT       = 100000,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [XLEN-1:0]  dataadr,
    input  logic [XLEN-1:0]  writedata,
    output logic             core_reset,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] write_count
);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_PASS, S_FAIL} state_e;
    typedef enum logic [1:0] {FC_NONE, FC_BAD_DATA, FC_BAD_ADDR, FC_TIMEOUT} fail_code_e;

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
    localparam logic [XLEN-1:0]   MBOX_ADDR  = XLEN'(PASS_ADDR);
    localparam logic [XLEN-1:0]   MBOX_DATA  = XLEN'(PASS_DATA);
    localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
    // Window bounds carry one extra bit so a window touching the top of the
    // address space does not wrap back to zero.
    localparam logic [XLEN:0]     WIN_LO     = {1'b0, XLEN'(SCRATCH_BASE)};
    localparam logic [XLEN:0]     WIN_HI     = WIN_LO + (XLEN + 1)'(SCRATCH_BYTES);

    state_e            state_q;
    fail_code_e        fail_code_q;
    logic [HOLD_W-1:0] hold_q;
    logic              core_reset_q, done_q, pass_q, fail_q;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]  write_count_q, write_count_d;

    logic [XLEN:0] addr_ext;
    logic          is_mbox, mbox_ok, in_window, timed_out;

    assign addr_ext  = {1'b0, dataadr};
    assign is_mbox   = (dataadr == MBOX_ADDR);
    assign mbox_ok   = (writedata == MBOX_DATA);
    assign in_window = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);

    assign cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
    assign write_count_d = (&write_count_q) ? write_count_q : write_count_q + 1'b1;
    assign timed_out     = (cycle_count_d >= TIMEOUT_C);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_HOLD;
            hold_q        <= '0;
            core_reset_q  <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_code_q   <= FC_NONE;
            cycle_count_q <= '0;
            write_count_q <= '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q      <= S_RUN;
                        core_reset_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_count_q <= cycle_count_d;
                    if (memwrite) write_count_q <= write_count_d;
                    // Decisive writes are checked before the timeout so a
                    // same-cycle pass/fail write takes precedence.
                    if (memwrite && is_mbox && mbox_ok) begin
                        state_q <= S_PASS;
                        pass_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (memwrite && is_mbox) begin
                        state_q     <= S_FAIL;
                        fail_q      <= 1'b1;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_BAD_DATA;
                    end else if (memwrite && !in_window) begin
                        state_q     <= S_FAIL;
                        fail_q      <= 1'b1;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_BAD_ADDR;
                    end else if (timed_out) begin
                        state_q     <= S_FAIL;
                        fail_q      <= 1'b1;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_TIMEOUT;
                    end
                end
                S_PASS, S_FAIL: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign core_reset  = core_reset_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_sim_result_monitor.sv
// Scoreboard bench for sim_result_monitor: expected terminal results are queued as
// stimulus is driven and compared once the monitor reports done.
module tb_sim_result_monitor;

    localparam int XLEN     = 32;
    localparam int CNT_W    = 32;
    localparam int RST_HOLD = 2;
    localparam int TIMEOUT  = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             memwrite;
    logic [XLEN-1:0]  dataadr, writedata;
    logic             core_reset, done, pass, fail;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] cycle_count, write_count;

    sim_result_monitor #(
        .XLEN(XLEN), .PASS_ADDR(84), .PASS_DATA(7), .SCRATCH_BASE(80), .SCRATCH_BYTES(4),
        .RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .core_reset(core_reset), .done(done), .pass(pass),
        .fail(fail), .fail_code(fail_code), .cycle_count(cycle_count),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pass;
        logic        fail;
        logic [1:0]  code;
        logic [31:0] cyc;
        logic [31:0] wr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_pass"},       64'(pass),       64'd0);
        check({tag, "_fail"},       64'(fail),       64'd0);
        check({tag, "_code"},       64'(fail_code),  64'd0);
        check({tag, "_cyc"},        64'(cycle_count), 64'd0);
        check({tag, "_wr"},         64'(write_count), 64'd0);
    endtask

    // Count cycles from reset release until core_reset drops (bounded).
    task automatic enter_run(input string tag);
        int n = 0;
        while (core_reset && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_hold_cycles"}, 64'(n), 64'(RST_HOLD));
        check({tag, "_run_cyc0"}, 64'(cycle_count), 64'd0);
    endtask

    task automatic start(input string tag, input bit check_reset);
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        tick(2);
        if (check_reset) check_idle({tag, "_rst"});
        reset = 1'b0;
        enter_run(tag);
    endtask

    // Idle `gap` RUN cycles, then drive one write cycle.
    task automatic write(input int gap, input logic [31:0] a, input logic [31:0] d);
        tick(gap);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic p, input logic f,
                                 input logic [1:0] code, input int cyc, input int wr);
        exp_t e;
        e.tag = tag; e.pass = p; e.fail = f; e.code = code;
        e.cyc = 32'(cyc); e.wr = 32'(wr);
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        int   i = 0;
        while (!done && i < 200) begin
            tick();
            i++;
        end
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({e.tag, "_done"}, 64'(done),        64'(e.pass | e.fail));
        check({e.tag, "_pass"}, 64'(pass),        64'(e.pass));
        check({e.tag, "_fail"}, 64'(fail),        64'(e.fail));
        check({e.tag, "_code"}, 64'(fail_code),   64'(e.code));
        check({e.tag, "_cyc"},  64'(cycle_count), 64'(e.cyc));
        check({e.tag, "_wr"},   64'(write_count), 64'(e.wr));
        check({e.tag, "_core_reset"}, 64'(core_reset), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Pass signature at RUN cycle 10: counters freeze at 11 / 1.
        start("pass10", 1'b1);
        expect_result("pass10", 1'b1, 1'b0, 2'd0, 11, 1);
        write(10, 32'd84, 32'd7);
        drain();
        tick(3);
        expect_result("pass10_frozen", 1'b1, 1'b0, 2'd0, 11, 1);
        drain();

        // Scratch write then pass.
        start("scratch", 1'b0);
        write(2, 32'd80, 32'd5);
        check("scratch_nofail", 64'(fail), 64'd0);
        expect_result("scratch_pass", 1'b1, 1'b0, 2'd0, 6, 2);
        write(2, 32'd84, 32'd7);
        drain();

        // Bad mailbox data, then a later good write must not flip to pass.
        start("baddata", 1'b0);
        expect_result("baddata", 1'b0, 1'b1, 2'd1, 2, 1);
        write(1, 32'd84, 32'd3);
        drain();
        expect_result("baddata_after", 1'b0, 1'b1, 2'd1, 2, 1);
        write(0, 32'd84, 32'd7);
        tick(2);
        drain();

        // Illegal addresses, including the top of the address space.
        start("addr100", 1'b0);
        expect_result("addr100", 1'b0, 1'b1, 2'd2, 1, 1);
        write(0, 32'h100, 32'hdead);
        drain();

        start("addrtop", 1'b0);
        expect_result("addrtop", 1'b0, 1'b1, 2'd2, 4, 1);
        write(3, 32'hFFFF_FFFF, 32'd7);
        drain();

        // Window edges: 83 is the last scratch byte, 79 is just below.
        start("winedge", 1'b0);
        write(0, 32'd83, 32'h55);
        check("winedge_83_nofail", 64'(fail), 64'd0);
        expect_result("winedge_79", 1'b0, 1'b1, 2'd2, 2, 2);
        write(0, 32'd79, 32'd1);
        drain();

        // Timeout with no writes.
        start("timeout", 1'b0);
        expect_result("timeout", 1'b0, 1'b1, 2'd3, TIMEOUT, 0);
        drain();

        // Decisive write in the timeout cycle wins; a scratch write does not.
        start("to_pass", 1'b0);
        expect_result("to_pass", 1'b1, 1'b0, 2'd0, TIMEOUT, 1);
        write(TIMEOUT - 1, 32'd84, 32'd7);
        drain();

        start("to_scratch", 1'b0);
        expect_result("to_scratch", 1'b0, 1'b1, 2'd3, TIMEOUT, 1);
        write(TIMEOUT - 1, 32'd81, 32'd9);
        drain();

        // Reset mid-run clears everything on the next edge and restarts HOLD.
        start("midrun", 1'b0);
        tick(5);
        check("midrun_cyc5", 64'(cycle_count), 64'd5);
        reset = 1'b1;
        tick();
        check_idle("midrun_rst");
        reset = 1'b0;
        enter_run("midrun_again");

        // Reset from a terminal state.
        expect_result("term_fail", 1'b0, 1'b1, 2'd2, 1, 1);
        write(0, 32'h0, 32'h0);
        drain();
        reset = 1'b1;
        tick();
        check_idle("term_rst");
        reset = 1'b0;
        enter_run("term_again");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
